// File: rtl/pipe_pkg.sv
// Shared definitions for elastic pipeline stage registers: occupancy states
// and bit positions inside the control bundle.
package pipe_pkg;

   typedef enum logic [1:0] {
      EMPTY = 2'd0,
      FULL  = 2'd1,
      SKID  = 2'd2
   } state_t;

   localparam int unsigned CTRL_MEM_READ   = 0;
   localparam int unsigned CTRL_MEM_WRITE  = 1;
   localparam int unsigned CTRL_REG_WRITE  = 2;
   localparam int unsigned CTRL_MEM_TO_REG = 3;
   localparam int unsigned CTRL_BDS_SEL    = 4;

endpackage

// File: rtl/pipe_stage_skid_reg_sat_counter.sv
// Saturating up-counter used for stage performance statistics; sticks at
// all-ones instead of wrapping.
module sat_counter #(
   parameter int unsigned CNT_W = 16
) (
   input  logic             i_clk,
   input  logic             i_reset,
   input  logic             i_inc,
   output logic [CNT_W-1:0] o_count
);

   always_ff @(posedge i_clk) begin
      if (!i_reset) begin
         o_count <= '0;
      end else if (i_inc && (o_count != '1)) begin
         o_count <= o_count + 1'b1;
      end
   end

endmodule

// File: rtl/pipe_stage_skid_reg.sv
// Elastic stage register with a two-entry skid buffer, flush, bubble-masked
// control and saturating stall/bubble counters.
module pipe_stage_skid_reg
   import pipe_pkg::*;
#(
   parameter int unsigned DATA_W = 32,
   parameter int unsigned CTRL_W = 5,
   parameter int unsigned CNT_W  = 16
) (
   input  logic              i_clk,
   input  logic              i_reset,
   input  logic              i_valid,
   output logic              o_ready,
   input  logic [CTRL_W-1:0] i_ctrl,
   input  logic [DATA_W-1:0] i_data,
   input  logic              i_flush,
   output logic              o_valid,
   input  logic              i_ready,
   output logic [CTRL_W-1:0] o_ctrl,
   output logic [DATA_W-1:0] o_data,
   output logic [CNT_W-1:0]  o_stall_cnt,
   output logic [CNT_W-1:0]  o_bubble_cnt
);

   state_t            state, state_n;
   logic [CTRL_W-1:0] main_ctrl, skid_ctrl;
   logic [DATA_W-1:0] main_data, skid_data;
   logic              ready_q;
   logic              up_xfer, dn_xfer;
   logic              load_main_in, load_main_skid, load_skid;

   assign o_valid = (state != EMPTY);
   assign o_ready = ready_q;
   assign up_xfer = i_valid & ready_q;
   assign dn_xfer = o_valid & i_ready;

   always_comb begin
      state_n        = state;
      load_main_in   = 1'b0;
      load_main_skid = 1'b0;
      load_skid      = 1'b0;
      case (state)
         EMPTY: begin
            if (up_xfer) begin
               state_n      = FULL;
               load_main_in = 1'b1;
            end
         end
         FULL: begin
            case ({up_xfer, dn_xfer})
               2'b01: state_n = EMPTY;
               2'b10: begin
                  state_n   = SKID;
                  load_skid = 1'b1;
               end
               2'b11: load_main_in = 1'b1;
               default: ;
            endcase
         end
         SKID: begin
            if (dn_xfer) begin
               state_n        = FULL;
               load_main_skid = 1'b1;
            end
         end
         default: state_n = EMPTY;
      endcase
      // Flush invalidates both entries but leaves the payload registers untouched.
      if (i_flush) begin
         state_n        = EMPTY;
         load_main_in   = 1'b0;
         load_main_skid = 1'b0;
         load_skid      = 1'b0;
      end
   end

   always_ff @(posedge i_clk) begin
      if (!i_reset) begin
         state     <= EMPTY;
         ready_q   <= 1'b1;
         main_ctrl <= '0;
         main_data <= '0;
         skid_ctrl <= '0;
         skid_data <= '0;
      end else begin
         state   <= state_n;
         ready_q <= (state_n != SKID);
         if (load_main_in) begin
            main_ctrl <= i_ctrl;
            main_data <= i_data;
         end else if (load_main_skid) begin
            main_ctrl <= skid_ctrl;
            main_data <= skid_data;
         end
         if (load_skid) begin
            skid_ctrl <= i_ctrl;
            skid_data <= i_data;
         end
      end
   end

   assign o_ctrl = main_ctrl & {CTRL_W{o_valid}};
   assign o_data = main_data;

   sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
      .i_clk   (i_clk),
      .i_reset (i_reset),
      .i_inc   (o_valid & ~i_ready),
      .o_count (o_stall_cnt)
   );

   sat_counter #(.CNT_W(CNT_W)) u_bubble_cnt (
      .i_clk   (i_clk),
      .i_reset (i_reset),
      .i_inc   (~o_valid),
      .o_count (o_bubble_cnt)
   );

endmodule

// File: tb/tb_pipe_stage_skid_reg.sv
// Scoreboard bench for pipe_stage_skid_reg: a default-width instance plus a
// CNT_W=4 instance sharing the same stimulus for counter saturation.
module tb_pipe_stage_skid_reg;
   import pipe_pkg::*;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        up_valid = 1'b0;
   logic [4:0]  up_ctrl = '0;
   logic [31:0] up_data = '0;
   logic        flush = 1'b0;
   logic        dn_ready = 1'b1;

   logic        up_ready, dn_valid;
   logic [4:0]  dn_ctrl;
   logic [31:0] dn_data;
   logic [15:0] stall_cnt, bubble_cnt;

   logic        ready4, valid4;
   logic [4:0]  ctrl4;
   logic [31:0] data4;
   logic [3:0]  stall4, bubble4;

   logic [36:0] sb_q[$];
   int          errors = 0;
   int          checks = 0;
   bit          started = 1'b0;
   bit          cyc_valid = 1'b0;
   bit          cyc_ready = 1'b1;
   int          exp_stall = 0, exp_bubble = 0, exp_stall4 = 0, exp_bubble4 = 0;
   logic [4:0]  mw_ctrl;
   logic [4:0]  c;

   always #5 clk = ~clk;

   pipe_stage_skid_reg #(.DATA_W(32), .CTRL_W(5), .CNT_W(16)) dut (
      .i_clk(clk), .i_reset(rst_n), .i_valid(up_valid), .o_ready(up_ready),
      .i_ctrl(up_ctrl), .i_data(up_data), .i_flush(flush), .o_valid(dn_valid),
      .i_ready(dn_ready), .o_ctrl(dn_ctrl), .o_data(dn_data),
      .o_stall_cnt(stall_cnt), .o_bubble_cnt(bubble_cnt)
   );

   pipe_stage_skid_reg #(.DATA_W(32), .CTRL_W(5), .CNT_W(4)) dut4 (
      .i_clk(clk), .i_reset(rst_n), .i_valid(up_valid), .o_ready(ready4),
      .i_ctrl(up_ctrl), .i_data(up_data), .i_flush(flush), .o_valid(valid4),
      .i_ready(dn_ready), .o_ctrl(ctrl4), .o_data(data4),
      .o_stall_cnt(stall4), .o_bubble_cnt(bubble4)
   );

   function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endfunction

   // Monitor: compares occupancy, counters and popped entries each cycle.
   always @(negedge clk) begin
      logic [36:0] e;
      if (started) begin
         cyc_valid = (sb_q.size() > 0);
         cyc_ready = (sb_q.size() < 2);
         chk("o_valid", 32'(dn_valid), 32'(cyc_valid));
         chk("o_ready", 32'(up_ready), 32'(cyc_ready));
         chk("o_valid_w4", 32'(valid4), 32'(cyc_valid));
         chk("o_ready_w4", 32'(ready4), 32'(cyc_ready));
         chk("stall_cnt", 32'(stall_cnt), exp_stall);
         chk("bubble_cnt", 32'(bubble_cnt), exp_bubble);
         chk("stall_cnt_w4", 32'(stall4), exp_stall4);
         chk("bubble_cnt_w4", 32'(bubble4), exp_bubble4);
         if (!cyc_valid) chk("bubble_ctrl", 32'(dn_ctrl), 32'd0);
         if (dn_valid && dn_ready && rst_n) begin
            if (sb_q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL sb_pop: got 0x%0h expected no output", dn_data);
            end else begin
               e = sb_q.pop_front();
               chk("sb_data", dn_data, e[31:0]);
               chk("sb_ctrl", 32'(dn_ctrl), 32'(e[36:32]));
               chk("sb_data_w4", data4, e[31:0]);
               chk("sb_ctrl_w4", 32'(ctrl4), 32'(e[36:32]));
            end
         end
      end
   end

   // Scoreboard update: pushes accepted inputs and advances counter expectations.
   initial forever begin
      @(negedge clk);
      #1;
      if (!rst_n) begin
         sb_q.delete();
         exp_stall = 0; exp_bubble = 0; exp_stall4 = 0; exp_bubble4 = 0;
      end else begin
         if (cyc_valid && !dn_ready) begin
            if (exp_stall < 65535) exp_stall++;
            if (exp_stall4 < 15) exp_stall4++;
         end
         if (!cyc_valid) begin
            if (exp_bubble < 65535) exp_bubble++;
            if (exp_bubble4 < 15) exp_bubble4++;
         end
         if (flush) sb_q.delete();
         else if (up_valid && cyc_ready) sb_q.push_back({up_ctrl, up_data});
      end
   end

   task automatic drive(input logic v, input logic [4:0] ct, input logic [31:0] d,
                        input logic r, input logic f, input logic rs);
      up_valid = v; up_ctrl = ct; up_data = d; dn_ready = r; flush = f; rst_n = rs;
      @(posedge clk);
      #1;
   endtask

   initial begin
      #200000;
      $display("FAIL timeout: got no finish expected finish");
      $fatal(1);
   end

   initial begin
      mw_ctrl = '0;
      mw_ctrl[CTRL_MEM_WRITE] = 1'b1;
      c = 5'b10101;
      drive(0, '0, '0, 1, 0, 0);
      started = 1'b1;
      drive(0, '0, '0, 1, 0, 0);
      chk("rst_valid", 32'(dn_valid), 32'd0);
      chk("rst_data", dn_data, 32'd0);
      chk("rst_ctrl", 32'(dn_ctrl), 32'd0);
      chk("rst_stall", 32'(stall_cnt), 32'd0);
      chk("rst_bubble", 32'(bubble_cnt), 32'd0);
      chk("rst_ready", 32'(up_ready), 32'd1);

      for (int i = 0; i < 4; i++) begin
         drive(0, mw_ctrl, 32'hDEAD, 1, 0, 1);
         chk("mask_ctrl", 32'(dn_ctrl), 32'd0);
      end
      chk("mask_bubble", 32'(bubble_cnt), 32'd4);

      for (int k = 1; k <= 8; k++) begin
         drive(1, 5'(k) ^ 5'h15, 32'(k), 1, 0, 1);
         chk("stream_data", dn_data, 32'(k));
         chk("stream_ready", 32'(up_ready), 32'd1);
      end
      drive(0, '0, '0, 1, 0, 1);
      chk("stream_stall", 32'(stall_cnt), 32'd0);

      drive(1, c, 32'hA, 1, 0, 1);
      drive(1, c, 32'hB, 0, 0, 1);
      chk("skid_ready", 32'(up_ready), 32'd0);
      chk("skid_data", dn_data, 32'hA);
      drive(0, '0, '0, 0, 0, 1);
      drive(0, '0, '0, 0, 0, 1);
      chk("skid_hold", dn_data, 32'hA);
      drive(0, '0, '0, 1, 0, 1);
      chk("skid_next", dn_data, 32'hB);
      drive(0, '0, '0, 1, 0, 1);
      chk("skid_drained", 32'(dn_valid), 32'd0);
      chk("skid_stall", 32'(stall_cnt), 32'd3);

      drive(1, c, 32'h11, 1, 0, 1);
      drive(1, c, 32'h12, 0, 0, 1);
      drive(1, mw_ctrl, 32'hC, 0, 1, 1);
      chk("flush_valid", 32'(dn_valid), 32'd0);
      chk("flush_ctrl", 32'(dn_ctrl), 32'd0);
      chk("flush_ready", 32'(up_ready), 32'd1);
      chk("flush_data", dn_data, 32'h11);
      drive(0, '0, '0, 1, 0, 1);

      drive(1, c, 32'h21, 1, 0, 1);
      drive(1, c, 32'h22, 1, 1, 1);
      chk("flushdn_valid", 32'(dn_valid), 32'd0);
      chk("flushdn_data", dn_data, 32'h21);
      drive(0, '0, '0, 1, 0, 1);
      chk("flush_stall", 32'(stall_cnt), 32'd5);

      drive(1, c, 32'h41, 1, 0, 1);
      for (int i = 0; i < 10; i++) drive(0, '0, '0, 0, 0, 1);
      chk("sat_reach", 32'(stall4), 32'd15);
      for (int i = 0; i < 10; i++) drive(0, '0, '0, 0, 0, 1);
      chk("sat_hold", 32'(stall4), 32'd15);
      chk("sat_wide", 32'(stall_cnt), 32'd25);

      drive(1, c, 32'h42, 0, 0, 1);
      chk("rstskid_ready", 32'(up_ready), 32'd0);
      drive(1, c, 32'h43, 1, 0, 0);
      chk("rstskid_valid", 32'(dn_valid), 32'd0);
      chk("rstskid_data", dn_data, 32'd0);
      chk("rstskid_ctrl", 32'(dn_ctrl), 32'd0);
      chk("rstskid_stall", 32'(stall_cnt), 32'd0);
      chk("rstskid_bubble", 32'(bubble_cnt), 32'd0);
      chk("rstskid_stall4", 32'(stall4), 32'd0);
      drive(0, '0, '0, 1, 0, 1);
      chk("rstskid_ready", 32'(up_ready), 32'd1);
      for (int i = 0; i < 3; i++) drive(0, '0, '0, 1, 0, 1);
      chk("sb_empty", 32'(sb_q.size()), 32'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/pipe_stage_skid_reg.md
Name: pipe_stage_skid_reg

Overview:
- Parametrised, elastic successor to the fixed EX/MEM stage register.
- Carries a generic control bundle plus data payload between pipeline stages using a valid/ready handshake.
- Contains a two-entry skid buffer, so upstream ready is registered and full throughput is kept under backpressure.
- Adds a flush, bubble-safe control masking, and saturating stall/bubble performance counters.
- Instantiated between EX and MEM, MEM and WB, or any other pair of stages.

Parameters:
- DATA_W, 32, total width of the data payload (ALU result, write data, write register, BDS, concatenated by the instantiator).
- CTRL_W, 5, width of the control bundle (mem_read, mem_write, reg_write, mem_to_reg, bds_sel).
- CNT_W, 16, width of each performance counter.

Ports:
- i_clk  in  1  clock; all logic on the rising edge.
- i_reset  in  1  synchronous reset, active-low.
- i_valid  in  1  upstream entry valid.
- o_ready  out  1  stage can accept; registered.
- i_ctrl  in  CTRL_W  upstream control bundle.
- i_data  in  DATA_W  upstream payload.
- i_flush  in  1  discard all held entries.
- o_valid  out  1  downstream entry valid.
- i_ready  in  1  downstream accepts.
- o_ctrl  out  CTRL_W  control bundle; forced to 0 when o_valid=0.
- o_data  out  DATA_W  payload.
- o_stall_cnt  out  CNT_W  cycles with o_valid=1 and i_ready=0.
- o_bubble_cnt  out  CNT_W  cycles with o_valid=0.

Behaviour:
- Reset (i_reset=0 at a clock edge):
  - State goes to EMPTY.
  - o_valid=0, o_ctrl=0, o_data=0, both counters 0, skid entry cleared.
  - o_ready=1 from the following cycle.
  - Reset overrides flush and any handshake in flight.
- Handshakes:
  - Upstream transfer: i_valid & o_ready.
  - Downstream transfer: o_valid & i_ready.
- States:
  - EMPTY: main entry empty, skid empty.
  - FULL: main entry holds the output, skid empty.
  - SKID: main and skid both occupied.
- Transitions (no flush):
  - EMPTY: upstream transfer -> load main, go to FULL. Latency is 1 cycle from input to o_valid.
  - FULL, downstream transfer only -> EMPTY.
  - FULL, upstream transfer only -> write skid, go to SKID.
  - FULL, both transfers -> reload main from input, stay FULL.
  - FULL, neither -> hold.
  - SKID, downstream transfer -> move skid into main, go to FULL. No upstream transfer is possible because o_ready=0.
  - SKID, no transfer -> hold.
- o_ready is 1 in EMPTY and FULL, and 0 in SKID.
- Order is strictly FIFO; no entry is ever duplicated or dropped except by flush or reset.
- Sustained throughput is one entry per cycle whenever i_ready=1.
- Flush:
  - When i_flush=1, the next state is EMPTY and both entries are invalidated.
  - Flush takes priority over a simultaneous upstream transfer; that input is discarded.
  - o_data keeps its last value. o_ctrl reads 0 because o_valid=0.
  - A downstream transfer in the same cycle as the flush still completes; the consumer sees it.
- Bubble masking:
  - o_ctrl = ctrl_main & {CTRL_W{o_valid}}.
  - A bubble therefore never asserts mem_write or reg_write.
- Counters:
  - Update every non-reset cycle from the current o_valid/i_ready.
  - Saturate at all-ones and never wrap.
  - Flush does not clear them.
- Hold behaviour: registers hold while no transfer occurs. This replaces the old enable input; i_ready=0 is the stall.

Decomposition:
- Shared package pipe_pkg contains:
  - The state encoding: EMPTY=2'd0, FULL=2'd1, SKID=2'd2.
  - Control-bit index constants: CTRL_MEM_READ=0, CTRL_MEM_WRITE=1, CTRL_REG_WRITE=2, CTRL_MEM_TO_REG=3, CTRL_BDS_SEL=4.
- One natural sub-module, sat_counter:
  - Parameter CNT_W.
  - Ports: i_clk, i_reset, i_inc, o_count.
  - Instantiated twice, once per counter.

Test Plan:
- Reset then i_valid=1, i_ready=1 with i_data=0x00000001..0x00000008 on consecutive cycles -> o_data shows 1..8 on consecutive cycles starting 1 cycle later; o_ready stays 1; o_stall_cnt=0.
- Load 0xA, then i_ready=0 while presenting 0xB -> state SKID, o_ready=0, o_data holds 0xA. Raise i_ready -> outputs 0xA, then 0xB; nothing is lost; o_stall_cnt equals the number of held cycles.
- State SKID, assert i_flush together with i_valid=1 and i_data=0xC -> next cycle o_valid=0, o_ctrl=0, o_ready=1. 0xC never appears at the output.
- i_ctrl=5'b00010 (mem_write) with i_valid=0 for 4 cycles after reset -> o_ctrl stays 0 throughout; o_bubble_cnt=4.
- CNT_W=4, o_valid=1, i_ready=0 for 20 cycles -> o_stall_cnt saturates at 15 and does not wrap.
- i_reset=0 asserted in state SKID with a transfer pending -> next cycle o_valid=0, o_data=0, counters=0; o_ready=1 once reset is released.
